// File: rtl/onehot_enc_pipe.sv
// onehot_enc_pipe: registered one-hot-to-binary encoder with valid/ready flow control and a saturating error counter.
// Define ONEHOT_RR_EN for round-robin resolution of multi-hot words (default: lowest set bit wins).
module onehot_enc_pipe #(
    parameter int N = 4,
    parameter int CNT_W = 8,
    localparam int W = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_idx,
    output logic             out_zero,
    output logic             out_multi,
    output logic [CNT_W-1:0] err_cnt
);
    logic             valid_q, zero_q, multi_q;
    logic [W-1:0]     idx_q, idx_d;
    logic [CNT_W-1:0] err_q;
    logic [N-1:0]     pick;
    logic             acc, zero_d, multi_d;

    assign in_ready = !valid_q || out_ready;
    assign acc      = in_valid && in_ready;
    assign zero_d   = in_data == '0;
    assign multi_d  = (in_data & (in_data - N'(1))) != '0;

`ifdef ONEHOT_RR_EN
    logic [W-1:0] last_q;
    logic [N-1:0] hi_mask;
    // Bits above the previous winner get first chance; otherwise wrap to the lowest set bit.
    always_comb begin
        hi_mask = '0;
        for (int i = 0; i < N; i++) hi_mask[i] = i > int'(last_q);
        pick = ((in_data & hi_mask) != '0) ? (in_data & hi_mask) : in_data;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) last_q <= W'(N - 1);
        else if (acc && !zero_d) last_q <= idx_d;
    end
`else
    assign pick = in_data;
`endif

    always_comb begin
        idx_d = '0;
        for (int i = N - 1; i >= 0; i--) if (pick[i]) idx_d = W'(i);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            idx_q   <= '0;
            zero_q  <= 1'b0;
            multi_q <= 1'b0;
            err_q   <= '0;
        end else begin
            if (acc) begin
                valid_q <= 1'b1;
                idx_q   <= idx_d;
                zero_q  <= zero_d;
                multi_q <= multi_d;
            end else if (out_ready) begin
                valid_q <= 1'b0;
            end
            if (acc && (zero_d || multi_d) && err_q != '1) err_q <= err_q + 1'b1;
        end
    end

    assign out_valid = valid_q;
    assign out_idx   = idx_q;
    assign out_zero  = zero_q;
    assign out_multi = multi_q;
    assign err_cnt   = err_q;
endmodule

// File: tb/tb_onehot_enc_pipe.sv
// tb_onehot_enc_pipe: table vectors, corner sequences and random traffic against a behavioural model.
module tb_onehot_enc_pipe;
    logic       clk = 1'b0, rst_n = 1'b0;
    logic       in_valid = 1'b0, out_ready = 1'b1;
    logic [3:0] in_data = '0;
    logic       in_ready, out_valid, out_zero, out_multi;
    logic [1:0] out_idx;
    logic [7:0] err_cnt;
    logic       in_ready_s, out_valid_s, out_zero_s, out_multi_s;
    logic [1:0] out_idx_s, err_cnt_s;

    int checks = 0, errors = 0;

    bit m_valid, m_zero, m_multi;
    int m_idx, m_cnt, m_last;

    onehot_enc_pipe #(.N(4), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx), .out_zero(out_zero),
        .out_multi(out_multi), .err_cnt(err_cnt)
    );

    onehot_enc_pipe #(.N(4), .CNT_W(2)) dut_s (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s), .in_data(in_data),
        .out_valid(out_valid_s), .out_ready(out_ready), .out_idx(out_idx_s), .out_zero(out_zero_s),
        .out_multi(out_multi_s), .err_cnt(err_cnt_s)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int ref_idx(input logic [3:0] d);
`ifdef ONEHOT_RR_EN
        for (int k = 0; k < 4; k++) if (d[(m_last + 1 + k) % 4]) return (m_last + 1 + k) % 4;
`else
        for (int k = 0; k < 4; k++) if (d[k]) return k;
`endif
        return 0;
    endfunction

    task automatic model_reset();
        m_valid = 0; m_zero = 0; m_multi = 0; m_idx = 0; m_cnt = 0; m_last = 3;
    endtask

    task automatic check_all();
        chk("in_ready", in_ready, !m_valid || out_ready);
        chk("out_valid", out_valid, m_valid);
        chk("out_idx", out_idx, m_idx);
        chk("out_zero", out_zero, m_zero);
        chk("out_multi", out_multi, m_multi);
        chk("err_cnt", err_cnt, m_cnt > 255 ? 255 : m_cnt);
        chk("out_valid_s", out_valid_s, m_valid);
        chk("out_idx_s", out_idx_s, m_idx);
        chk("err_cnt_s", err_cnt_s, m_cnt > 3 ? 3 : m_cnt);
    endtask

    task automatic step(input bit v, input logic [3:0] d, input bit r);
        @(negedge clk);
        in_valid = v; in_data = d; out_ready = r;
        #1;
        chk("in_ready_pre", in_ready, !m_valid || r);
        chk("in_ready_pre_s", in_ready_s, !m_valid || r);
        @(posedge clk);
        if (v && (!m_valid || r)) begin
            m_idx = ref_idx(d);
            m_valid = 1;
            m_zero = d == 0;
            m_multi = $countones(d) > 1;
            if (m_zero || m_multi) m_cnt++;
            if (d != 0) m_last = m_idx;
        end else if (r) begin
            m_valid = 0;
        end
        #1;
        check_all();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct {
        bit v; logic [3:0] d; bit r;
        bit ev; int idx; bit z; bit m; int err;
    } vec_t;

    vec_t tbl[7];
    int sat_exp[5];
    int rr_exp[6];
    logic [3:0] rr_in[6];

    initial begin
        tbl[0] = '{1, 4'b0001, 1, 1, 0, 0, 0, 0};
        tbl[1] = '{1, 4'b0010, 1, 1, 1, 0, 0, 0};
        tbl[2] = '{1, 4'b0100, 1, 1, 2, 0, 0, 0};
        tbl[3] = '{1, 4'b1000, 1, 1, 3, 0, 0, 0};
        tbl[4] = '{1, 4'b0000, 1, 1, 0, 1, 0, 1};
        tbl[5] = '{1, 4'b1010, 1, 1, 1, 0, 1, 2};
        tbl[6] = '{0, 4'b0000, 1, 0, 1, 0, 1, 2};
        sat_exp = '{1, 2, 3, 3, 3};
        rr_in = '{4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b0000, 4'b1111};
`ifdef ONEHOT_RR_EN
        rr_exp = '{0, 1, 2, 3, 0, 0};
`else
        rr_exp = '{0, 0, 0, 0, 0, 0};
`endif
        model_reset();
        #2;
        chk("reset_in_ready", in_ready, 1);
        chk("reset_valid", out_valid, 0);
        do_reset();

        for (int i = 0; i < 7; i++) begin
            step(tbl[i].v, tbl[i].d, tbl[i].r);
            chk($sformatf("tbl%0d_valid", i), out_valid, tbl[i].ev);
            chk($sformatf("tbl%0d_idx", i), out_idx, tbl[i].idx);
            chk($sformatf("tbl%0d_zero", i), out_zero, tbl[i].z);
            chk($sformatf("tbl%0d_multi", i), out_multi, tbl[i].m);
            chk($sformatf("tbl%0d_err", i), err_cnt, tbl[i].err);
        end

        step(1, 4'b0100, 1);
        for (int i = 0; i < 3; i++) begin
            step(1, 4'b0001, 0);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_idx_held", out_idx, 2);
            chk("bp_valid_held", out_valid, 1);
        end
        step(1, 4'b0001, 1);
        chk("bp_release_idx", out_idx, 0);
        step(0, 4'b0000, 1);
        chk("bp_drain_valid", out_valid, 0);

        do_reset();
        for (int i = 0; i < 5; i++) begin
            step(1, 4'b0000, 1);
            chk($sformatf("sat%0d", i), err_cnt_s, sat_exp[i]);
        end

        do_reset();
        step(1, 4'b0000, 1);
        step(1, 4'b0100, 1);
        step(1, 4'b0010, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", out_valid, 0);
        chk("arst_idx", out_idx, 0);
        chk("arst_zero", out_zero, 0);
        chk("arst_err", err_cnt, 0);
        chk("arst_in_ready", in_ready, 1);
        model_reset();
        check_all();
        @(negedge clk);
        rst_n = 1'b1;

        do_reset();
        for (int i = 0; i < 6; i++) begin
            step(1, rr_in[i], 1);
            chk($sformatf("rr%0d_idx", i), out_idx, rr_exp[i]);
        end
        chk("rr_err", err_cnt, 6);

        do_reset();
        for (int i = 0; i < 3000; i++) begin
            logic [3:0] d;
            d = ($urandom_range(0, 1) != 0) ? (4'b0001 << $urandom_range(0, 3)) : 4'($urandom);
            step($urandom_range(0, 3) != 0, d, $urandom_range(0, 3) != 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/onehot_enc_pipe.md
# onehot_enc_pipe

Parametrised, registered one-hot-to-binary encoder with valid/ready flow control on both sides. It is the generalised successor to the team's fixed 4-to-2 encoder: N-bit request word in, binary index out, plus zero/multi-hot detection and a saturating error counter. It sits between request-generating logic and any consumer that needs a binary index, and can absorb consumer back-pressure without dropping words.

## Interface
- `N`, default 4: input word width; must be ≥ 2.
- `W`, default `$clog2(N)`: index width. Localparam, not overridable.
- `CNT_W`, default 8: error counter width.

Ports (clock and reset first):
- `clk`, input, 1: single clock; all logic on the rising edge.
- `rst_n`, input, 1: reset, asynchronous, active-low.
- `in_valid`, input, 1: `in_data` is valid.
- `in_ready`, output, 1: block can accept a word.
- `in_data`, input, N: request word, expected one-hot.
- `out_valid`, output, 1: output register holds a result.
- `out_ready`, input, 1: consumer accepts the result.
- `out_idx`, output, W: encoded bit position.
- `out_zero`, output, 1: the accepted word was all-zero.
- `out_multi`, output, 1: the accepted word had more than one bit set.
- `err_cnt`, output, CNT_W: count of accepted zero or multi-hot words, saturating.

## Operation
- **Accept:** an input transfer occurs when `in_valid && in_ready`. An output transfer occurs when `out_valid && out_ready`.
- **Ready rule:** `in_ready = !out_valid || out_ready`. This is combinational from `out_ready`, with no other path.
- **On accept:** `out_idx`, `out_zero` and `out_multi` are loaded from `in_data`, and `out_valid` becomes 1.
- **Output held:** if there is an output transfer and no input transfer, `out_valid` becomes 0. Data outputs hold their last value.
- **Stall:** while `out_valid && !out_ready`, all outputs are stable.
- **Index rule (default):** fixed priority, lowest set bit wins.
  - Example with N=4: `0100` gives index 2; `0110` gives index 1 with `out_multi=1`.
- **Zero word:** `out_idx=0`, `out_zero=1`, `out_multi=0`.
- **Exactly one bit set:** `out_zero=0` and `out_multi=0`.
- **`err_cnt`:** increments by 1 on each accepted word with `out_zero` or `out_multi` set. It saturates at 2^CNT_W−1 and never wraps.
- **Reset values:**
  - Outputs: `out_valid=0`, `out_idx=0`, `out_zero=0`, `out_multi=0`, `err_cnt=0`.
  - Ready: `in_ready` is 1 during and after reset, since it is derived from `out_valid=0`.
- **Reset mid-operation:** asserting `rst_n=0` immediately clears all registers, including a pending stalled result. That result is discarded and not replayed.

## Timing
- **Latency:** 1 cycle. Data accepted at edge k is visible on the outputs after edge k, and is consumable at edge k+1.
- **Throughput:** one word per cycle when `out_ready=1` continuously.
- **Simultaneous transfers:** input and output transfers in the same cycle replace the result. `out_valid` stays 1 with no bubble.
- **Combinational paths:** `in_ready` depends only on `out_valid` (registered) and `out_ready`. There is no path from `in_valid` to any output.
- **Counter:** `err_cnt` updates on the same edge as the input transfer that causes the increment.

## Configuration
- **Macro:** `ONEHOT_RR_EN`.
- **Undefined:** fixed lowest-bit priority, exactly as in Operation.
- **Defined:** round-robin resolution of multi-hot words.
  - State register `last_idx` (W bits) resets to N−1.
  - The search for a set bit starts at `(last_idx+1) mod N` and wraps around.
  - `last_idx` loads the produced index on each accepted non-zero word.
  - Zero words leave `last_idx` unchanged.
  - One-hot words give the same index as in fixed mode.
  - `out_zero`, `out_multi` and `err_cnt` behave identically in both modes.

## Test plan
- **Reset and one-hot sweep:** apply reset, then N=4 with `out_ready=1`, feeding `0001`, `0010`, `0100`, `1000` on consecutive cycles. Expect `out_idx` of 0, 1, 2, 3, one cycle after each word; flags stay 0; `err_cnt` stays 0; `in_ready` stays 1.
- **Error words:** feed `0000`, then `1010`. Expect `out_zero=1` with idx 0, then `out_multi=1` with idx 1 (fixed mode); `err_cnt` goes 1, then 2.
- **Back-pressure:** accept `0100`, then hold `out_ready=0` for 3 cycles while `in_valid=1` with `0001`. Expect `in_ready=0`, idx 2 held stable, and `0001` not accepted until `out_ready` rises. After that, idx 0 appears on the next cycle with no word lost or duplicated.
- **Saturation:** with CNT_W=2, feed 5 zero words. Expect `err_cnt` to read 1, 2, 3, 3, 3.
- **Reset mid-stall:** stall with `out_valid=1`, then pulse `rst_n=0` asynchronously. Expect all outputs to go to their reset values immediately, with no clock edge needed, and `err_cnt=0`.
- **Round-robin (`ONEHOT_RR_EN`):** feed `1111` four times, then `0000`, then `1111`. Expect idx 0, 1, 2, 3; then idx 0 with `out_zero=1`; then idx 0, because the search wraps from `last_idx=3`. `err_cnt` reaches 6.
